// File: rtl/keccak_pkg.sv
// Shared types and limits for the Keccak-f round controller.
package keccak_pkg;

   localparam int unsigned NUM_ROUNDS_MAX = 24;
   localparam int unsigned ROUND_W        = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_OUT  = 2'd3
   } keccak_state_e;

endpackage

// File: rtl/keccak_round_ctrl_if.sv
// Control handshake between the Keccak round controller and its host/datapath.
interface keccak_round_ctrl_if;
   import keccak_pkg::*;

   logic               start;
   logic               ready;
   logic               abort;
   logic               hold;
   logic               load_en;
   logic               round_en;
   logic [ROUND_W-1:0] round_number;
   logic               last_round;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output start, abort, hold, out_ready,
      input  ready, load_en, round_en, round_number, last_round, out_valid
   );

   modport slave (
      input  start, abort, hold, out_ready,
      output ready, load_en, round_en, round_number, last_round, out_valid
   );
endinterface

// File: rtl/keccak_round_counter.sv
// Round index counter: clears, counts on enable, saturates at the last round.
module keccak_round_counter
   import keccak_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               enable,
   output logic [ROUND_W-1:0] count,
   output logic               tc
);

   localparam logic [ROUND_W-1:0] LAST = ROUND_W'(NUM_ROUNDS - 1);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && !tc) begin
         count <= count + ROUND_W'(1);
      end
   end

   assign tc = (count == LAST);

endmodule

// File: rtl/keccak_round_ctrl.sv
// Sequences one Keccak-f permutation: load strobe, NUM_ROUNDS round enables, result handshake.
module keccak_round_ctrl
   import keccak_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 24
) (
   input  logic                clk,
   input  logic                rst,
   keccak_round_ctrl_if.slave  bus
);

   if (NUM_ROUNDS < 1 || NUM_ROUNDS > NUM_ROUNDS_MAX) begin : g_bad_rounds
      $error("keccak_round_ctrl: NUM_ROUNDS out of range 1..24");
   end

   keccak_state_e      state;
   keccak_state_e      state_nxt;
   logic               ready;
   logic               load_en;
   logic               round_en;
   logic               cnt_clear;
   logic               tc;
   logic [ROUND_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Outputs decode from state plus hold/abort only; start/out_ready steer the next state.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      load_en   = 1'b0;
      round_en  = 1'b0;
      cnt_clear = 1'b0;
      case (state)
         ST_IDLE: begin
            ready = 1'b1;
            if (bus.start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            load_en   = !bus.abort;
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            round_en = !bus.hold && !bus.abort;
            if (round_en && tc) state_nxt = ST_OUT;
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               state_nxt = ST_IDLE;
               cnt_clear = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (bus.abort) begin
         state_nxt = ST_IDLE;
         cnt_clear = 1'b1;
      end
   end

   keccak_round_counter #(.NUM_ROUNDS(NUM_ROUNDS)) u_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (round_en),
      .count  (count),
      .tc     (tc)
   );

   assign bus.ready        = ready;
   assign bus.load_en      = load_en;
   assign bus.round_en     = round_en;
   assign bus.round_number = count;
   assign bus.last_round   = round_en && tc;
   assign bus.out_valid    = (state == ST_OUT);

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Self-checking bench for keccak_round_ctrl with 24-round and 1-round instances.
module tb_keccak_round_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   keccak_round_ctrl_if b24 ();
   keccak_round_ctrl_if b1 ();

   keccak_round_ctrl #(.NUM_ROUNDS(24)) dut24 (.clk(clk), .rst(rst), .bus(b24));
   keccak_round_ctrl #(.NUM_ROUNDS(1))  dut1  (.clk(clk), .rst(rst), .bus(b1));

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit known    = 1'b0;
   // Model progress: 0 idle, 1 load, 2..n+1 round (k-2), n+2 result waiting.
   int k [2]    = '{0, 0};
   int nr [2]   = '{24, 1};
   int first_ov = -1;
   int ld_cnt   = 0;
   int r1_cnt   = 0;
   int t0       = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input int i, input string nm, input bit hd, input bit ab,
                            input logic rdy, input logic ld, input logic re,
                            input logic [4:0] rn, input logic lr, input logic ov);
      int  n;
      bit  in_run;
      bit  e_re;
      int  e_rn;
      n      = nr[i];
      in_run = (k[i] >= 2) && (k[i] <= n + 1);
      e_re   = in_run && !hd && !ab;
      e_rn   = in_run ? k[i] - 2 : ((k[i] == n + 2) ? n - 1 : 0);
      chk({nm, ".ready"},        8'(rdy), 8'(k[i] == 0));
      chk({nm, ".load_en"},      8'(ld),  8'((k[i] == 1) && !ab));
      chk({nm, ".round_en"},     8'(re),  8'(e_re));
      chk({nm, ".round_number"}, 8'(rn),  8'(e_rn));
      chk({nm, ".last_round"},   8'(lr),  8'(e_re && (k[i] == n + 1)));
      chk({nm, ".out_valid"},    8'(ov),  8'(k[i] == n + 2));
   endtask

   function automatic int next_k(input int kk, input int n, input bit st, input bit ab,
                                 input bit hd, input bit ordy);
      if (ab) return 0;
      if (kk == 0) return st ? 1 : 0;
      if (kk == 1) return 2;
      if (kk <= n + 1) return hd ? kk : kk + 1;
      return ordy ? 0 : kk;
   endfunction

   task automatic cycle(input bit r, input bit st, input bit ab, input bit hd, input bit ordy);
      @(negedge clk);
      rst = r;
      b24.start = st; b24.abort = ab; b24.hold = hd; b24.out_ready = ordy;
      b1.start  = st; b1.abort  = ab; b1.hold  = hd; b1.out_ready  = ordy;
      #1;
      if (!r && known) begin
         check_dut(0, "n24", hd, ab, b24.ready, b24.load_en, b24.round_en,
                   b24.round_number, b24.last_round, b24.out_valid);
         check_dut(1, "n1", hd, ab, b1.ready, b1.load_en, b1.round_en,
                   b1.round_number, b1.last_round, b1.out_valid);
      end
      if (b24.out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
      if (b24.load_en === 1'b1) ld_cnt++;
      if (b1.round_en === 1'b1) r1_cnt++;
      @(posedge clk);
      if (r) begin
         k[0] = 0; k[1] = 0; known = 1'b1;
      end else begin
         for (int i = 0; i < 2; i++) k[i] = next_k(k[i], nr[i], st, ab, hd, ordy);
      end
      cyc++;
   endtask

   task automatic advance_to(input int tgt, input int budget);
      int b;
      b = budget;
      while (k[0] != tgt && b > 0) begin
         cycle(0, 0, 0, 0, 1);
         b--;
      end
      chk("advance_budget", 8'(k[0] == tgt), 8'd1);
   endtask

   task automatic run_to_out_valid(input int budget);
      int b;
      b = budget;
      while (first_ov < 0 && b > 0) begin
         cycle(0, 0, 0, 0, 1);
         b--;
      end
      chk("out_valid_budget", 8'(first_ov >= 0), 8'd1);
   endtask

   initial begin
      b24.start = 0; b24.abort = 0; b24.hold = 0; b24.out_ready = 0;
      b1.start  = 0; b1.abort  = 0; b1.hold  = 0; b1.out_ready  = 0;

      // Reset and idle
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 1);

      // Nominal run; 1-round instance must give exactly one round_en
      first_ov = -1; r1_cnt = 0; t0 = cyc;
      cycle(0, 1, 0, 0, 1);
      run_to_out_valid(40);
      chk("nominal_latency", 8'(first_ov - t0), 8'd26);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
      chk("n1_round_en_pulses", 8'(r1_cnt), 8'd1);

      // Stall three cycles at round 10
      first_ov = -1; t0 = cyc;
      cycle(0, 1, 0, 0, 1);
      advance_to(12, 40);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1);
      run_to_out_valid(40);
      chk("stall_latency", 8'(first_ov - t0), 8'd29);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

      // Backpressure in OUT with an ignored start, then start+out_ready together
      cycle(0, 1, 0, 0, 1);
      advance_to(26, 40);
      ld_cnt = 0;
      for (int i = 0; i < 5; i++) cycle(0, (i == 2), 0, 0, 0);
      chk("backpressure_no_load", 8'(ld_cnt), 8'd0);
      cycle(0, 1, 0, 0, 1);
      chk("start_in_out_ignored", 8'(k[0]), 8'd0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);

      // Abort at round 7
      cycle(0, 1, 0, 0, 1);
      advance_to(9, 40);
      cycle(0, 0, 1, 1, 1);
      first_ov = -1;
      for (int i = 0; i < 30; i++) cycle(0, 0, 0, 0, 1);
      chk("abort_no_out_valid", 8'(first_ov < 0), 8'd1);

      // Reset at round 15, then a fresh permutation
      cycle(0, 1, 0, 0, 1);
      advance_to(17, 40);
      cycle(1, 1, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      first_ov = -1; t0 = cyc;
      cycle(0, 1, 0, 0, 1);
      run_to_out_valid(40);
      chk("post_reset_latency", 8'(first_ov - t0), 8'd26);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 1) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
